lcd_text_feeder: RTL and testbench
==================================

# lcd_text_feeder

Upstream companion of the 1602A LCD driver. It holds a character frame buffer (up to 2 lines × 16 columns) that the host writes at any time. It streams the buffer to the driver as a sequence of driver commands: INIT and CLEAR once after reset, then one DDRAM-address CONFIG per line followed by SEND_DATA per character. Every transfer uses the driver's `en`/`op`/`data_in` inputs and its `lcd_rdy` ready output.

## Interface
- `COLS`, 16, characters per line (1..16).
- `LINES`, 2, display lines (1 or 2).
- `REFRESH_DIV`, 400000, clk cycles between automatic refreshes (20 ms at 20 MHz). Used only with the auto-refresh macro.
- `clk`  input  1  system clock, 20 MHz.
- `rst`  input  1  reset, synchronous, active-low.
- `wr_en`  input  1  host write strobe for the frame buffer.
- `wr_addr`  input  5  buffer index, line*16+col.
- `wr_data`  input  8  character code.
- `refresh_req`  input  1  host request for a frame refresh.
- `drv_rdy`  input  1  driver ready (driver `lcd_rdy`).
- `drv_en`  output  1  one-cycle command strobe to the driver `en`.
- `drv_op`  output  3  driver op index: 0 INIT, 1 CONFIG, 2 SEND_DATA, 3 CLEAR.
- `drv_data`  output  8  command byte or character to the driver `data_in`.
- `busy`  output  1  high while any state other than IDLE is active.
- `frame_done`  output  1  one-cycle pulse after the last character of a frame.
- `err`  output  1  sticky flag: the driver failed to acknowledge a command.

## Operation
- Buffer: `COLS`*`LINES` bytes, all reset to 0x20 (space).
  - `wr_en` writes `wr_data` at `wr_addr` in any state.
  - A write with `wr_addr` ≥ COLS*LINES is ignored.
  - Any accepted write sets `dirty`.
- FSM states: START, ISSUE, WAIT_ACK, WAIT_DONE, IDLE.
  - A step counter selects the current command.
  - Init sequence: INIT (data 0x00), then CLEAR (data 0x01), then IDLE.
  - Frame sequence:
    - CONFIG 0x80 (line 0 address), then SEND_DATA for buf[0..COLS-1].
    - If LINES=2: CONFIG 0xC0, then SEND_DATA for buf[16..16+COLS-1].
    - After the last character: pulse `frame_done`, go to IDLE.
- IDLE starts a frame when `dirty`, the pending-refresh flag, or the auto-refresh tick is set. Frame start clears `dirty` and pending-refresh.
- `refresh_req` in any state sets pending-refresh. Several requests collapse into one frame.
- ISSUE waits for `drv_rdy`=1, then drives `drv_en`=1 for exactly one cycle with `drv_op`/`drv_data`, then goes to WAIT_ACK.
- WAIT_ACK waits for `drv_rdy`=0, then goes to WAIT_DONE.
  - If `drv_rdy` stays 1 for 16 cycles, set `err` and treat the command as complete.
- WAIT_DONE waits for `drv_rdy`=1, then advances the step and goes to ISSUE (or IDLE / `frame_done`).
- Character data is sampled from the buffer in the ISSUE cycle. A write to a position not yet sent appears in the current frame. A write to a position already sent appears in the next frame, because `dirty` re-arms.

## Timing
- Reset values: `drv_en`=0, `drv_op`=0, `drv_data`=0x00, `busy`=1, `frame_done`=0, `err`=0. State=START, `dirty`=0, pending=0.
- START→ISSUE happens in the first cycle after reset deasserts.
- `drv_en` is asserted in the cycle after ISSUE sees `drv_rdy`=1. `drv_op`/`drv_data` hold their values until the next ISSUE.
- Minimum spacing between two `drv_en` pulses is 3 cycles.
- Frame length: LINES*(COLS+1) commands, i.e. 34 for the defaults.
- `frame_done` is asserted in the same cycle the FSM enters IDLE. `busy` drops in that cycle.
- Simultaneous `wr_en` and frame start: the write lands and `dirty` stays set (set wins over clear).
- `rst` low mid-frame: everything returns to reset values, the buffer refills with spaces, and INIT is re-issued.
- `err` clears only on reset.

## Configuration
- `LCD_FEEDER_AUTOREFRESH_EN` defined:
  - A 20-bit counter runs continuously.
  - When it reaches REFRESH_DIV-1 it wraps to 0 and sets pending-refresh.
  - The counter resets to 0 with `rst`.
- Not defined: no counter. Frames start only on `dirty` or `refresh_req`. `REFRESH_DIV` is unused.

## Test plan
- Reset release with a driver model that acks in 10 cycles → `drv_en` pulses carry op 0/data 0x00, then op 3/data 0x01; then IDLE with `busy`=0 and no further `drv_en`.
- Write 'H' (0x48) at addr 0 and 'i' (0x69) at addr 17 → 34 commands: CONFIG 0x80, 0x48, 15×0x20, CONFIG 0xC0, 0x20, 0x69, 14×0x20; then one `frame_done` pulse.
- Write to addr 0 while char 5 is being sent → that frame is unchanged, and a second frame starts automatically with the new byte at position 0.
- Driver model holding `drv_rdy`=1 permanently after INIT → `err`=1 after 16 cycles; the sequence still advances to CLEAR.
- `rst`=0 during char 10 of a frame → outputs reach reset values next cycle; after release, INIT is re-issued and the buffer reads all 0x20.
- With `LCD_FEEDER_AUTOREFRESH_EN` and REFRESH_DIV=1000, no writes → frames start every 1000 cycles. Without the macro → no frames after init.

Source files
------------

// File: rtl/lcd_text_feeder.sv
// rtl/lcd_text_feeder.sv - frame buffer and command sequencer feeding a 1602A LCD driver
// Optional auto-refresh timer: LCD_FEEDER_AUTOREFRESH_EN
module lcd_text_feeder #(
  parameter int COLS        = 16,
  parameter int LINES       = 2,
  parameter int REFRESH_DIV = 400000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  logic [4:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  input  logic       i_refresh_req,
  input  logic       i_drv_rdy,
  output logic       o_drv_en,
  output logic [2:0] o_drv_op,
  output logic [7:0] o_drv_data,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_err
);

  localparam int         NCHAR     = COLS * LINES;
  localparam logic [4:0] COL_LAST  = 5'(COLS);
  localparam logic       LINE_LAST = 1'(LINES - 1);

  localparam logic [2:0] OP_INIT   = 3'd0;
  localparam logic [2:0] OP_CONFIG = 3'd1;
  localparam logic [2:0] OP_DATA   = 3'd2;
  localparam logic [2:0] OP_CLEAR  = 3'd3;

  typedef enum logic [2:0] {
    S_START,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_IDLE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [7:0]  r_buf [0:31];
  logic        r_dirty;
  logic        r_pending;
  logic        r_init;     // 1 while running the INIT/CLEAR sequence
  logic        r_line;
  logic [4:0]  r_col;      // init: step index; frame: 0 = CONFIG, 1..COLS = characters
  logic [3:0]  r_ack_cnt;

  logic        w_tick;
  logic        w_fire;
  logic        w_done;
  logic        w_timeout;
  logic        w_start;
  logic        w_last;
  logic        w_wr_ok;
  logic [4:0]  w_rd_idx;
  logic [2:0]  w_op;
  logic [7:0]  w_data;

  assign w_wr_ok  = i_wr_en && (int'(i_wr_addr) < NCHAR);
  assign w_rd_idx = {r_line, 4'b0000} + r_col - 5'd1;
  assign w_last   = r_init ? (r_col == 5'd1)
                           : ((r_line == LINE_LAST) && (r_col == COL_LAST));
  assign o_busy   = (r_state != S_IDLE);

`ifdef LCD_FEEDER_AUTOREFRESH_EN
  localparam logic [19:0] REF_MAX = 20'(REFRESH_DIV - 1);
  logic [19:0] r_ref_cnt;

  // Free-running refresh timer, wraps at REFRESH_DIV-1
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_ref_cnt <= '0;
    end else if (r_ref_cnt == REF_MAX) begin
      r_ref_cnt <= '0;
    end else begin
      r_ref_cnt <= r_ref_cnt + 20'd1;
    end
  end

  assign w_tick = (r_ref_cnt == REF_MAX);
`else
  // No refresh timer in this build
  assign w_tick = 1'b0 && (REFRESH_DIV != 0);
`endif

  // Command selection for the current step; buffer is read live in ISSUE
  always_comb begin
    w_op   = OP_INIT;
    w_data = 8'h00;
    if (r_init) begin
      if (r_col != 5'd0) begin
        w_op   = OP_CLEAR;
        w_data = 8'h01;
      end
    end else if (r_col == 5'd0) begin
      w_op   = OP_CONFIG;
      w_data = r_line ? 8'hC0 : 8'h80;
    end else begin
      w_op   = OP_DATA;
      w_data = r_buf[w_rd_idx];
    end
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    w_next    = r_state;
    w_fire    = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    w_start   = 1'b0;
    case (r_state)
      S_START: w_next = S_ISSUE;
      S_ISSUE: begin
        if (i_drv_rdy) begin
          w_fire = 1'b1;
          w_next = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (!i_drv_rdy) begin
          w_next = S_WAIT_DONE;
        end else if (r_ack_cnt == 4'd15) begin
          w_timeout = 1'b1;
          w_done    = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (i_drv_rdy) begin
          w_done = 1'b1;
        end
      end
      S_IDLE: begin
        if (r_dirty || r_pending || w_tick) begin
          w_start = 1'b1;
          w_next  = S_ISSUE;
        end
      end
      default: w_next = S_START;
    endcase
    if (w_done) begin
      w_next = w_last ? S_IDLE : S_ISSUE;
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_START;
    end else begin
      r_state <= w_next;
    end
  end

  // Step counter: init steps, then line/column walk through the frame
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_init <= 1'b1;
      r_line <= 1'b0;
      r_col  <= 5'd0;
    end else if (w_start) begin
      r_init <= 1'b0;
      r_line <= 1'b0;
      r_col  <= 5'd0;
    end else if (w_done && !w_last) begin
      if (!r_init && (r_col == COL_LAST)) begin
        r_line <= 1'b1;
        r_col  <= 5'd0;
      end else begin
        r_col <= r_col + 5'd1;
      end
    end
  end

  // Counts cycles the driver keeps rdy high after a strobe
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_ack_cnt <= 4'd0;
    end else if (w_fire) begin
      r_ack_cnt <= 4'd0;
    end else if ((r_state == S_WAIT_ACK) && i_drv_rdy) begin
      r_ack_cnt <= r_ack_cnt + 4'd1;
    end
  end

  // Driver-facing outputs; op/data hold between strobes
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_drv_en     <= 1'b0;
      o_drv_op     <= OP_INIT;
      o_drv_data   <= 8'h00;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_drv_en     <= w_fire;
      o_frame_done <= w_done && w_last && !r_init;
      if (w_fire) begin
        o_drv_op   <= w_op;
        o_drv_data <= w_data;
      end
      if (w_timeout) begin
        o_err <= 1'b1;
      end
    end
  end

  // Frame buffer and dirty flag; a write wins over the frame-start clear
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < 32; i++) begin
        r_buf[i] <= 8'h20;
      end
      r_dirty <= 1'b0;
    end else if (w_wr_ok) begin
      r_buf[i_wr_addr] <= i_wr_data;
      r_dirty          <= 1'b1;
    end else if (w_start) begin
      r_dirty <= 1'b0;
    end
  end

  // Pending refresh; a request arriving with the frame start queues another frame
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_pending <= 1'b0;
    end else if (w_start) begin
      r_pending <= i_refresh_req;
    end else if (i_refresh_req || w_tick) begin
      r_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_text_feeder.sv
// tb/tb_lcd_text_feeder.sv - directed self-checking bench for lcd_text_feeder
module tb_lcd_text_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       refresh_req;
  logic       drv_rdy = 1'b1;
  logic       drv_en;
  logic [2:0] drv_op;
  logic [7:0] drv_data;
  logic       busy;
  logic       frame_done;
  logic       err;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [10:0] cmds [$];
  int         fd_cnt = 0;
  logic       stuck = 1'b0;
  int         dcnt = 0;
  logic [7:0] exp_buf [0:31];

  lcd_text_feeder #(.COLS(16), .LINES(2), .REFRESH_DIV(1000)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wr_en       (wr_en),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .i_refresh_req (refresh_req),
    .i_drv_rdy     (drv_rdy),
    .o_drv_en      (drv_en),
    .o_drv_op      (drv_op),
    .o_drv_data    (drv_data),
    .o_busy        (busy),
    .o_frame_done  (frame_done),
    .o_err         (err)
  );

  always #25 clk = ~clk;

  // Driver model: rdy drops after a strobe and returns 9 cycles later
  always @(posedge clk) begin
    if (stuck) begin
      drv_rdy <= 1'b1;
      dcnt    <= 0;
    end else if (drv_en) begin
      drv_rdy <= 1'b0;
      dcnt    <= 9;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) drv_rdy <= 1'b1;
    end
  end

  // Command and frame_done monitor
  always @(negedge clk) begin
    if (drv_en) cmds.push_back({drv_op, drv_data});
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_cmds(input string tag, input int target, input int budget);
    int k = 0;
    while (cmds.size() < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, cmds.size() >= target}, 32'd1);
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int k = 0;
    while (fd_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, fd_cnt >= target}, 32'd1);
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic pulse_refresh();
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
  endtask

  task automatic check_frame(input string tag, input int base);
    logic [10:0] exp;
    logic [10:0] got;
    for (int s = 0; s < 34; s++) begin
      int line = s / 17;
      int col  = s % 17;
      if (col == 0) exp = {3'd1, (line != 0) ? 8'hC0 : 8'h80};
      else          exp = {3'd2, exp_buf[line * 16 + col - 1]};
      got = (base + s < cmds.size()) ? cmds[base + s] : 11'h7FF;
      check($sformatf("%s[%0d]", tag, s), {21'd0, got}, {21'd0, exp});
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(3);
    cmds.delete();
    fd_cnt = 0;
    clear_model();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; refresh_req = 1'b0;
    clear_model();
    tick(3);
    check("rst_drv_en", {31'd0, drv_en}, 32'd0);
    check("rst_drv_op", {29'd0, drv_op}, 32'd0);
    check("rst_drv_data", {24'd0, drv_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // Init sequence, then quiet
    rst = 1'b1;
    wait_idle("init_idle", 500);
    check("init_n", cmds.size(), 2);
    check("init_cmd0", {21'd0, cmds[0]}, {21'd0, 3'd0, 8'h00});
    check("init_cmd1", {21'd0, cmds[1]}, {21'd0, 3'd3, 8'h01});
    tick(1500);
`ifdef LCD_FEEDER_AUTOREFRESH_EN
    check("auto_frames", {31'd0, fd_cnt > 0}, 32'd1);
    wait_idle("auto_idle", 1000);
    cmds.delete();
    fd_cnt = 0;
`else
    check("quiet_frames", fd_cnt, 0);
    check("quiet_cmds", cmds.size(), 2);
    check("quiet_busy", {31'd0, busy}, 32'd0);
    cmds.delete();

    // Refresh request; repeated requests mid-frame collapse into one frame
    pulse_refresh();
    wait_cmds("refr_mid", 5, 500);
    pulse_refresh();
    tick(3);
    pulse_refresh();
    tick(3);
    pulse_refresh();
    wait_frames("refr_done", 2, 3000);
    wait_idle("refr_idle", 500);
    tick(100);
    check("refr_frames", fd_cnt, 2);
    check("refr_cmds", cmds.size(), 68);
    check_frame("refr_f0", 0);
    check_frame("refr_f1", 34);
`endif

    // Writes during init show up in the first frame
    do_reset();
    host_write(5'd0, 8'h48);
    host_write(5'd17, 8'h69);
    exp_buf[0] = 8'h48;
    exp_buf[17] = 8'h69;
    wait_frames("hi_done", 1, 3000);
    wait_idle("hi_idle", 500);
    tick(200);
    check("hi_frames", fd_cnt, 1);
    check("hi_cmds", cmds.size(), 36);
    check("hi_init", {21'd0, cmds[0]}, {21'd0, 3'd0, 8'h00});
    check("hi_clear", {21'd0, cmds[1]}, {21'd0, 3'd3, 8'h01});
    check_frame("hi", 2);

    // Write to an already-sent position re-arms a second frame
    cmds.delete();
    fd_cnt = 0;
    pulse_refresh();
    wait_cmds("mid_ch5", 7, 500);
    host_write(5'd0, 8'h5A);
    wait_frames("mid_done", 2, 3000);
    wait_idle("mid_idle", 500);
    tick(100);
    check("mid_frames", fd_cnt, 2);
    check("mid_cmds", cmds.size(), 68);
    check_frame("mid_f0", 0);
    exp_buf[0] = 8'h5A;
    check_frame("mid_f1", 34);

    // Driver that never drops rdy: timeout sets err, sequence continues
    rst = 1'b0;
    stuck = 1'b1;
    do_reset();
    wait_cmds("stk_init", 1, 200);
    tick(5);
    check("stk_err_early", {31'd0, err}, 32'd0);
    wait_idle("stk_idle", 500);
    check("stk_err", {31'd0, err}, 32'd1);
    check("stk_cmds", cmds.size(), 2);
    check("stk_clear", {21'd0, cmds[1]}, {21'd0, 3'd3, 8'h01});
    stuck = 1'b0;

    // Reset mid-frame during char 10
    do_reset();
    wait_idle("mr_init", 500);
    host_write(5'd3, 8'h41);
    wait_cmds("mr_ch10", 2 + 12, 1000);
    rst = 1'b0;
    tick(1);
    check("mr_drv_en", {31'd0, drv_en}, 32'd0);
    check("mr_drv_op", {29'd0, drv_op}, 32'd0);
    check("mr_drv_data", {24'd0, drv_data}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd1);
    check("mr_err", {31'd0, err}, 32'd0);
    do_reset();
    wait_idle("mr_reinit", 500);
    check("mr_cmds", cmds.size(), 2);
    check("mr_init", {21'd0, cmds[0]}, {21'd0, 3'd0, 8'h00});
    cmds.delete();
    pulse_refresh();
    wait_frames("mr_done", 1, 3000);
    tick(50);
    check_frame("mr_spaces", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
